reg_file_disp_np: RTL

// - Parametrised multi-read-port register file with hardwired-zero register 0.
// - Adds a run-time selectable display tap: captures one watched register into a display latch.
// - Drives static 7-segment outputs plus a time-multiplexed (scanned) digit interface.
// - Sits in the CPU datapath between decode/writeback and the board's HEX displays.

---
 rtl/reg_file_disp_np.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/reg_file_disp_np.sv
// ============================================================================
// Module      : reg_file_disp_np
// Description : Multi-read-port register file (r0 hardwired to zero) with a
//               watched-register display latch, static 7-segment decode and a
//               scanned digit interface. Define REG_FILE_BYPASS_EN for
//               write-through forwarding on the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_disp_np #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic [NUM_RD*ADDR_W-1:0]   read_reg,
    output logic [NUM_RD*DATA_W-1:0]   read_data,
    input  logic [ADDR_W-1:0]          disp_sel,
    input  logic                       disp_hold,
    output logic [4*NUM_DIGITS-1:0]    disp_value,
    output logic                       disp_update,
    output logic [7*NUM_DIGITS-1:0]    segments,
    output logic [6:0]                 scan_seg,
    output logic [NUM_DIGITS-1:0]      scan_an
);

    localparam int c_DEPTH  = 1 << ADDR_W;
    localparam int c_DISP_W = 4 * NUM_DIGITS;
    localparam int c_CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Active-low segment pattern, bit0 = a ... bit6 = g
    function automatic logic [6:0] f_hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [DATA_W-1:0]   r_rf [c_DEPTH];
    logic [c_DISP_W-1:0] r_disp_value;
    logic                r_disp_update;
    logic [ADDR_W-1:0]   r_disp_sel_q;
    logic [c_CNT_W-1:0]  r_scan_cnt;
    logic [c_IDX_W-1:0]  r_digit;

    logic                w_load;
    logic [c_DISP_W-1:0] w_disp_next;
    logic                w_scan_wrap;
    logic [6:0]          w_seg [NUM_DIGITS];

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_rf[i] <= '0;
            end
        end else if (reg_write && (write_reg != '0)) begin
            r_rf[write_reg] <= write_data;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = read_reg[p*ADDR_W +: ADDR_W];
`ifdef REG_FILE_BYPASS_EN
            assign read_data[p*DATA_W +: DATA_W] =
                (w_addr == '0)                         ? '0         :
                (reg_write && (write_reg == w_addr))   ? write_data :
                                                         r_rf[w_addr];
`else
            assign read_data[p*DATA_W +: DATA_W] =
                (w_addr == '0) ? '0 : r_rf[w_addr];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Display latch: a write to the watched register beats a select change
    // ------------------------------------------------------------------
    always_comb begin
        w_load      = 1'b0;
        w_disp_next = r_disp_value;
        if (!disp_hold) begin
            if (reg_write && (write_reg == disp_sel) && (disp_sel != '0)) begin
                w_load      = 1'b1;
                w_disp_next = write_data[c_DISP_W-1:0];
            end else if (disp_sel != r_disp_sel_q) begin
                w_load      = 1'b1;
                w_disp_next = (disp_sel == '0) ? '0 : r_rf[disp_sel][c_DISP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp_value  <= '0;
            r_disp_update <= 1'b0;
        end else begin
            r_disp_value  <= w_disp_next;
            r_disp_update <= w_load;
        end
    end

    // Tracks the select even under hold or reset, so a change made while
    // frozen is not replayed later.
    always_ff @(posedge clk) begin
        r_disp_sel_q <= disp_sel;
    end

    assign disp_value  = r_disp_value;
    assign disp_update = r_disp_update;

    // ------------------------------------------------------------------
    // Static decode and digit scanning
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_seg
            assign w_seg[k]           = f_hex7(r_disp_value[4*k +: 4]);
            assign segments[7*k +: 7] = w_seg[k];
        end
    endgenerate

    assign w_scan_wrap = (r_scan_cnt == c_CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
        end else if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_digit    <= (r_digit == c_IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign scan_an  = ~(NUM_DIGITS'(1) << r_digit);
    assign scan_seg = w_seg[r_digit];

endmodule

`default_nettype wire
